rom_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the shared 8x4 combinational ROM (ROM_addr[2:0] -> ROM_data[3:0]).
- Two requesters (e.g. display path and ALU operand fetch) issue read requests; block grants round-robin, drives the ROM address, and returns registered data with a one-cycle ack pulse.
- Sits between the requesters and the ROM instance; the ROM itself is unchanged.

---
 rtl/rom_arbiter_if.sv | 29 ++
 rtl/rom_arbiter.sv | 91 +++++++++
 tb/tb_rom_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_if.sv
// Request/ack bus between the two ROM requesters, the arbiter and the shared ROM.
// master = requesters + ROM side, slave = arbiter side.
interface rom_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              busy;
  logic [7:0]        conflict_cnt;

  modport master (
    output req0, addr0, req1, addr1, rom_data,
    input  ack0, rdata0, ack1, rdata1, rom_addr, busy, conflict_cnt
  );

  modport slave (
    input  req0, addr0, req1, addr1, rom_data,
    output ack0, rdata0, ack1, rdata1, rom_addr, busy, conflict_cnt
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin two-port arbiter/sequencer for the shared 8x4 combinational ROM.
// Optional conflict counter enabled by defining ROM_ARB_CONFLICT_CNT_EN.
module rom_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rom_arbiter_if.slave bus
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [ADDR_W-1:0] ADDR_RST = '0;
  localparam logic [DATA_W-1:0] DATA_RST = '0;

  state_t state;
  logic   grant_r;
  logic   last_grant;
  logic   eff_req0;
  logic   eff_req1;

  // A port's request is masked while its ack is high so it can drop req after seeing ack.
  assign eff_req0 = bus.req0 & ~bus.ack0;
  assign eff_req1 = bus.req1 & ~bus.ack1;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_r    <= 1'b0;
      last_grant <= 1'b1;
      bus.rom_addr <= ADDR_RST;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.rdata0 <= DATA_RST;
      bus.rdata1 <= DATA_RST;
      bus.busy   <= 1'b0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (eff_req0 && (!eff_req1 || last_grant)) begin
            bus.rom_addr <= bus.addr0;
            grant_r      <= 1'b0;
            state        <= READ;
            bus.busy     <= 1'b1;
          end else if (eff_req1) begin
            bus.rom_addr <= bus.addr1;
            grant_r      <= 1'b1;
            state        <= READ;
            bus.busy     <= 1'b1;
          end
        end
        READ: begin
          if (grant_r) begin
            bus.rdata1 <= bus.rom_data;
            bus.ack1   <= 1'b1;
          end else begin
            bus.rdata0 <= bus.rom_data;
            bus.ack0   <= 1'b1;
          end
          last_grant <= grant_r;
          state      <= IDLE;
          bus.busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROM_ARB_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;

  // Counts IDLE cycles where both ports contend; saturates and clears only on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= 8'h00;
    end else if (state == IDLE && eff_req0 && eff_req1 && conflict_cnt != 8'hFF) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

  assign bus.conflict_cnt = conflict_cnt;
`else
  assign bus.conflict_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed testbench for rom_arbiter; ROM modelled as data = addr + 5 (mod 16).
// Expected conflict_cnt follows ROM_ARB_CONFLICT_CNT_EN.
module tb_rom_arbiter;

`ifdef ROM_ARB_CONFLICT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   n_ack0;
  int   n_ack1;
  int   base0;
  int   base1;

  rom_arbiter_if #(.ADDR_W(3), .DATA_W(4)) bus ();

  rom_arbiter #(.ADDR_W(3), .DATA_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.rom_data = {1'b0, bus.rom_addr} + 4'h5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ack0) n_ack0++;
    if (bus.ack1) n_ack1++;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic conflict_rounds(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      tick();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      tick();
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_ack0   = 0;
    n_ack1   = 0;
    rst_n    = 1'b0;
    bus.req0 = 1'b1;
    bus.addr0 = 3'd3;
    bus.req1 = 1'b0;
    bus.addr1 = 3'd0;

    // Reset held with req0 active
    tick();
    tick();
    check("rst_ack0", 8'(bus.ack0), 8'h0);
    check("rst_ack1", 8'(bus.ack1), 8'h0);
    check("rst_rdata0", 8'(bus.rdata0), 8'h0);
    check("rst_rdata1", 8'(bus.rdata1), 8'h0);
    check("rst_rom_addr", 8'(bus.rom_addr), 8'h0);
    check("rst_busy", 8'(bus.busy), 8'h0);
    check("rst_cnt", bus.conflict_cnt, 8'h00);

    // First read after release: grant on edge 1, ack on edge 2
    rst_n = 1'b1;
    tick();
    check("p0_grant_addr", 8'(bus.rom_addr), 8'h3);
    check("p0_busy", 8'(bus.busy), 8'h1);
    check("p0_no_early_ack", 8'(bus.ack0), 8'h0);
    tick();
    check("p0_ack", 8'(bus.ack0), 8'h1);
    check("p0_rdata", 8'(bus.rdata0), 8'h8);
    check("p0_busy_low", 8'(bus.busy), 8'h0);
    bus.req0 = 1'b0;
    tick();
    check("p0_ack_pulse", 8'(bus.ack0), 8'h0);
    check("p0_rdata_hold", 8'(bus.rdata0), 8'h8);

    // Single port 1 request; address change after grant must not matter
    base0 = n_ack0;
    base1 = n_ack1;
    bus.req1 = 1'b1;
    bus.addr1 = 3'd7;
    tick();
    check("p1_grant_addr", 8'(bus.rom_addr), 8'h7);
    bus.req1 = 1'b0;
    bus.addr1 = 3'd0;
    tick();
    check("p1_ack", 8'(bus.ack1), 8'h1);
    check("p1_rdata", 8'(bus.rdata1), 8'hC);
    check("p1_rdata0_kept", 8'(bus.rdata0), 8'h8);
    tick();
    tick();
    tick();
    check("p1_one_ack", 8'(n_ack1 - base1), 8'd1);
    check("p1_no_ack0", 8'(n_ack0 - base0), 8'd0);
    check("p1_rdata_hold", 8'(bus.rdata1), 8'hC);
    check("p1_rom_addr_hold", 8'(bus.rom_addr), 8'h7);

    // Tie after reset: port 0 first, then alternate
    do_reset();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.addr0 = 3'd1;
    bus.addr1 = 3'd2;
    tick();
    check("tie_first_addr", 8'(bus.rom_addr), 8'h1);
    check("tie_cnt", bus.conflict_cnt, CNT_EN ? 8'd1 : 8'd0);
    tick();
    check("tie_ack0", 8'(bus.ack0), 8'h1);
    check("tie_rdata0", 8'(bus.rdata0), 8'h6);
    check("tie_no_ack1", 8'(bus.ack1), 8'h0);
    tick();
    check("tie_second_addr", 8'(bus.rom_addr), 8'h2);
    tick();
    check("tie_ack1", 8'(bus.ack1), 8'h1);
    check("tie_rdata1", 8'(bus.rdata1), 8'h7);
    for (int k = 0; k < 2; k++) begin
      tick();
      tick();
      check("alt_ack0", 8'(bus.ack0), 8'h1);
      check("alt_ack0_only", 8'(bus.ack1), 8'h0);
      tick();
      tick();
      check("alt_ack1", 8'(bus.ack1), 8'h1);
      check("alt_ack1_only", 8'(bus.ack0), 8'h0);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    tick();
    check("alt_cnt", bus.conflict_cnt, CNT_EN ? 8'd1 : 8'd0);

    // Back-to-back on port 0: req masked during ack, regranted one cycle later
    bus.req0 = 1'b1;
    bus.addr0 = 3'd0;
    tick();
    tick();
    check("b2b_ack_a", 8'(bus.ack0), 8'h1);
    check("b2b_rdata_a", 8'(bus.rdata0), 8'h5);
    bus.addr0 = 3'd4;
    tick();
    check("b2b_masked", 8'(bus.busy), 8'h0);
    tick();
    check("b2b_regrant_addr", 8'(bus.rom_addr), 8'h4);
    bus.req0 = 1'b0;
    tick();
    check("b2b_ack_b", 8'(bus.ack0), 8'h1);
    check("b2b_rdata_b", 8'(bus.rdata0), 8'h9);
    tick();

    // Reset during the READ cycle of a port 1 request
    base1 = n_ack1;
    bus.req1 = 1'b1;
    bus.addr1 = 3'd5;
    tick();
    check("mid_busy", 8'(bus.busy), 8'h1);
    bus.req1 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_busy_clr", 8'(bus.busy), 8'h0);
    check("mid_rdata1", 8'(bus.rdata1), 8'h0);
    check("mid_rom_addr", 8'(bus.rom_addr), 8'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("mid_no_ack1", 8'(n_ack1 - base1), 8'd0);
    check("idle_busy", 8'(bus.busy), 8'h0);
    check("idle_ack0", 8'(bus.ack0), 8'h0);
    check("idle_rom_addr", 8'(bus.rom_addr), 8'h0);
    check("idle_rdata1", 8'(bus.rdata1), 8'h0);

    // Conflict counter: 10 rounds, then saturate after 300 total
    conflict_rounds(10);
    check("cnt_10", bus.conflict_cnt, CNT_EN ? 8'd10 : 8'd0);
    conflict_rounds(290);
    check("cnt_sat", bus.conflict_cnt, CNT_EN ? 8'hFF : 8'h00);
    conflict_rounds(2);
    check("cnt_sat_hold", bus.conflict_cnt, CNT_EN ? 8'hFF : 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
